// File: rtl/opfetch_defs_pkg.sv
// ============================================================================
// Module      : opfetch_defs_pkg
// Description : Shared state encoding and default sizing for operand_fetch_wb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package opfetch_defs_pkg;

  localparam int c_DEF_WIDTH   = 16;
  localparam int c_DEF_REGBITS = 3;
  localparam int c_DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_wb.sv
// ============================================================================
// Module      : operand_fetch_wb
// Description : Fetches Rn/Rm through the single regfile read port, runs the
//               ALU handshake and writes the result back to Rd.
//               Optional ALU timeout: define OPFETCH_ALU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_wb
  import opfetch_defs_pkg::*;
#(
  parameter int WIDTH          = c_DEF_WIDTH,
  parameter int REGBITS        = c_DEF_REGBITS,
  parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [REGBITS-1:0] rn,
  input  logic [REGBITS-1:0] rm,
  input  logic [REGBITS-1:0] rd,
  input  logic               wb_en,
  output logic               busy,
  output logic [REGBITS-1:0] readnum,
  input  logic [WIDTH-1:0]   rf_data_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               op_valid,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_valid,
  output logic [REGBITS-1:0] writenum,
  output logic               write,
  output logic [WIDTH-1:0]   data_in,
  output logic               done,
  output logic               err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REGBITS-1:0] r_rn;
  logic [REGBITS-1:0] r_rm;
  logic [REGBITS-1:0] r_rd;
  logic               r_wb_en;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               w_timeout;

`ifdef OPFETCH_ALU_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_tcnt;
  logic               r_err;

  // Counter is zero in the first EXEC cycle, so the limit hits on EXEC cycle N.
  assign w_timeout = (r_state == ST_EXEC) && !alu_valid &&
                     (r_tcnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != ST_EXEC)
        r_tcnt <= '0;
      else if (!alu_valid)
        r_tcnt <= r_tcnt + 1'b1;
      if (r_state == ST_IDLE && start)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err = (r_state == ST_DONE) && r_err;
`else
  localparam int c_timeout_unused = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_FETCH_A;
      ST_FETCH_A: w_state_nxt = ST_FETCH_B;
      ST_FETCH_B: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (alu_valid)      w_state_nxt = r_wb_en ? ST_WB : ST_DONE;
        else if (w_timeout) w_state_nxt = ST_DONE;
      end
      ST_WB:      w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    readnum  = '0;
    write    = 1'b0;
    op_valid = 1'b0;
    done     = 1'b0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_FETCH_A: readnum  = r_rn;
      ST_FETCH_B: readnum  = r_rm;
      ST_EXEC:    op_valid = 1'b1;
      ST_WB:      write    = 1'b1;
      ST_DONE:    done     = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rn     <= '0;
      r_rm     <= '0;
      r_rd     <= '0;
      r_wb_en  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_rn    <= rn;
        r_rm    <= rm;
        r_rd    <= rd;
        r_wb_en <= wb_en;
      end
      if (r_state == ST_FETCH_A) r_a <= rf_data_out;
      if (r_state == ST_FETCH_B) r_b <= rf_data_out;
      if (r_state == ST_EXEC && alu_valid) r_result <= alu_result;
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign writenum = r_rd;
  assign data_in  = r_result;

endmodule

`default_nettype wire

// File: doc/operand_fetch_wb.md
Name: operand_fetch_wb

Overview:
- Sequencer between the 8x16 register file and the ALU.
- Uses the regfile's single combinational read port to fetch two operands, Rn then Rm, into A/B registers.
- Hands A/B to the ALU with a valid/valid handshake, captures the result, and writes it back to Rd through the regfile write port.
- One operation in flight at a time; start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 16, datapath width of regfile data and ALU operands.
- REGBITS, 3, register index width (8 registers).
- TIMEOUT_CYCLES, 15, max EXEC cycles waiting for alu_valid; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- rn  in  REGBITS  operand A register index; captured on start accept.
- rm  in  REGBITS  operand B register index; captured on start accept.
- rd  in  REGBITS  destination register index; captured on start accept.
- wb_en  in  1  1 = write result to rd; 0 = discard (compare-style op); captured on start accept.
- busy  out  1  high in every state except IDLE.
- readnum  out  REGBITS  to regfile readnum.
- rf_data_out  in  WIDTH  from regfile data_out (combinational on readnum).
- a_out  out  WIDTH  latched operand A.
- b_out  out  WIDTH  latched operand B.
- op_valid  out  1  A/B valid to ALU; high only in EXEC.
- alu_result  in  WIDTH  ALU result.
- alu_valid  in  1  result valid; honoured only in EXEC.
- writenum  out  REGBITS  to regfile writenum (= rd_q).
- write  out  1  to regfile write; high only in WB.
- data_in  out  WIDTH  to regfile data_in (= registered result).
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag, valid with done; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: a_out, b_out, data_in, readnum, writenum, write, op_valid, done, err, busy. Captured indices and wb_en also 0.
- Reset mid-operation: write deasserts immediately and no partial writeback occurs. After reset_n rises, the block resumes from IDLE.
- States: IDLE, FETCH_A, FETCH_B, EXEC, WB, DONE.
- IDLE: if start=1 at a posedge, capture rn/rm/rd/wb_en, then go to FETCH_A.
- FETCH_A: readnum=rn_q; at posedge, a_out<=rf_data_out; go to FETCH_B.
- FETCH_B: readnum=rm_q; at posedge, b_out<=rf_data_out; go to EXEC.
- EXEC: op_valid=1. At a posedge with alu_valid=1, result_q<=alu_result; go to WB if wb_en_q, else DONE. With alu_valid=0, stay in EXEC.
- WB: write=1, writenum=rd_q, data_in=result_q; the regfile writes at this posedge; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- readnum is 0 outside FETCH_A/FETCH_B. writenum and data_in are held stable outside WB.
- Latency from the start-accept edge, with alu_valid in the first EXEC cycle: done is high in the 5th cycle after accept (4th if wb_en=0). Each extra EXEC wait cycle adds 1.
- start while busy=1 is ignored; it is not queued. start held high re-triggers on the IDLE cycle after DONE.
- rn==rm is legal; both operands get the same value. rd==rn or rd==rm is legal; writeback occurs strictly after both fetches, so operands hold the old value.
- a_out and b_out hold their values until the next fetch.

Optional Feature:
- Macro OPFETCH_ALU_TIMEOUT_EN.
- Defined: a counter clears on entry to EXEC and increments each EXEC cycle without alu_valid. When it reaches TIMEOUT_CYCLES with alu_valid=0, the block goes to DONE without writeback, and done=1 with err=1.
- alu_valid on the same edge as the limit wins: normal completion, err=0.
- Undefined: no counter; EXEC waits indefinitely; err constant 0.

Decomposition:
- Shared package/include opfetch_defs:
  - state encoding localparams (3-bit, IDLE=0);
  - default WIDTH/REGBITS;
  - TIMEOUT_CYCLES default.
- Single module. The timeout counter stays inline; no sub-module is warranted.

Test Plan:
- Preload the regfile with R1=0x0007 and R2=0xF000; start rn=1, rm=2, rd=3, wb_en=1, ALU=add returning alu_valid the first EXEC cycle. Expect: a_out=0x0007, b_out=0xF000; write high for one cycle with writenum=3 and data_in=0xF007; done 5 cycles after accept; R3 reads 0xF007.
- Same op with wb_en=0 and R3 preloaded 0x1111: write never asserts, done 4 cycles after accept, R3 still 0x1111.
- rn=rm=rd=7 with R7=0x7777, ALU=add: a_out=b_out=0x7777, R7 becomes 0xEEEE after WB.
- Hold alu_valid low for 3 EXEC cycles, then result 0x0001 to rd=0: op_valid high for 4 cycles, done at cycle 8 after accept, R0=0x0001. Pulses of start during busy cause no second operation.
- Assert reset_n=0 during WB: write drops to 0 asynchronously and all outputs are 0. After release, busy=0 and a new start completes normally.
- OPFETCH_ALU_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, alu_valid never asserted: done=1, err=1 after 15 EXEC cycles, no write. Repeat with alu_valid on the 15th cycle: err=0 and writeback occurs.
